// File: rtl/ccff_bitstream_loader_if.sv
// Word handshake between the SoC management logic (master) and the bitstream loader (slave).
interface ccff_bitstream_loader_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serial writer for the ccff_head/ccff_tail configuration chain: words in, MSB-first bits out.
// Define CCFF_READBACK_EN to collect ccff_tail into rb_data words during the load.
module ccff_bitstream_loader #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CHAIN_LEN  = 2048,
  parameter int unsigned CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset,
  input  logic                   start,
  ccff_bitstream_loader_if.slave word_bus,
  output logic                   ccff_head,
  output logic                   ccff_shift_en,
  input  logic                   ccff_tail,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   bit_count,
  output logic [WORD_WIDTH-1:0]  rb_data,
  output logic                   rb_valid
);
  localparam int unsigned          LeftWidth = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] ChainLen  = CNT_WIDTH'(CHAIN_LEN);
  localparam logic [LeftWidth-1:0] WordBits  = LeftWidth'(WORD_WIDTH);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  bit_count_q, bit_count_d;
  logic [LeftWidth-1:0]  bits_left_q, bits_left_d;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  last_bit;
  logic                  word_ready;

  assign word_bus.word_ready = word_ready;
  assign bit_count           = bit_count_q;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_count_d   = bit_count_q;
    bits_left_d   = bits_left_q;
    word_ready    = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    remaining     = ChainLen - bit_count_q;
    last_bit      = (bit_count_q + CNT_WIDTH'(1)) == ChainLen;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          bit_count_d = '0;
        end
      end
      StLoad: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (word_bus.word_valid) begin
          shreg_d = word_bus.word_data;
          // The final word may only need its upper bits to finish the chain.
          if (32'(remaining) >= WORD_WIDTH) begin
            bits_left_d = WordBits;
          end else begin
            bits_left_d = LeftWidth'(remaining);
          end
          state_d = StShift;
        end
      end
      StShift: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = shreg_q[WORD_WIDTH-1];
        shreg_d       = shreg_q << 1;
        bit_count_d   = bit_count_q + CNT_WIDTH'(1);
        bits_left_d   = bits_left_q - LeftWidth'(1);
        if (last_bit) begin
          state_d = StDone;
        end else if (bits_left_q == LeftWidth'(1)) begin
          state_d = StLoad;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_count_q <= '0;
      bits_left_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_count_q <= bit_count_d;
      bits_left_q <= bits_left_d;
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_WIDTH-1:0] rb_shreg_q, rb_shreg_d;
  logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
  logic [WORD_WIDTH-1:0] rb_next;
  logic [LeftWidth-1:0]  rb_cnt_q, rb_cnt_d;
  logic                  rb_valid_q, rb_valid_d;

  always_comb begin
    rb_shreg_d = rb_shreg_q;
    rb_data_d  = rb_data_q;
    rb_cnt_d   = rb_cnt_q;
    rb_valid_d = 1'b0;
    rb_next    = (rb_shreg_q << 1) | WORD_WIDTH'(ccff_tail);
    if (state_q == StIdle && start) begin
      rb_shreg_d = '0;
      rb_cnt_d   = '0;
    end else if (ccff_shift_en) begin
      // Clearing after each emit keeps a short final word right-aligned and zero-extended.
      if (rb_cnt_q == WordBits - LeftWidth'(1) || last_bit) begin
        rb_data_d  = rb_next;
        rb_valid_d = 1'b1;
        rb_shreg_d = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_shreg_d = rb_next;
        rb_cnt_d   = rb_cnt_q + LeftWidth'(1);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      rb_shreg_q <= '0;
      rb_data_q  <= '0;
      rb_cnt_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_shreg_q <= rb_shreg_d;
      rb_data_q  <= rb_data_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader (8-bit words, 20-bit chain) with a bit-stream model and a
// 20-bit chain model on ccff_tail.
module tb_ccff_bitstream_loader;
  localparam int unsigned W  = 8;
  localparam int unsigned L  = 20;
  localparam int unsigned CW = $clog2(L + 1);
  localparam logic [L-1:0] ChainPreload = 20'hABCDE;

  logic          prog_clk = 1'b0;
  logic          prog_reset, start, ccff_head, ccff_shift_en, ccff_tail;
  logic          busy, done, rb_valid;
  logic [CW-1:0] bit_count;
  logic [W-1:0]  rb_data;

  ccff_bitstream_loader_if #(.WORD_WIDTH(W)) word_bus ();

  ccff_bitstream_loader #(
    .WORD_WIDTH(W),
    .CHAIN_LEN (L)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (start),
    .word_bus     (word_bus.slave),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .bit_count    (bit_count),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid)
  );

  always #5 prog_clk = ~prog_clk;

  // Configuration chain: head enters at bit 0, tail leaves from the top bit.
  logic [L-1:0] chain_q;
  logic         chain_load;
  always @(posedge prog_clk) begin
    if (chain_load) chain_q <= ChainPreload;
    else if (ccff_shift_en) chain_q <= {chain_q[L-2:0], ccff_head};
  end
  assign ccff_tail = chain_q[L-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Model state: expected bit stream and readback words for the current load.
  bit           exp_stream[$];
  logic [W-1:0] rb_exp[$];
  logic [W-1:0] rb_got[$];
  int           pos = 0, shift_cnt = 0, done_cnt = 0;
  logic [L-1:0] captured = '0;
  bit           active = 0, last_final = 0, was_idle = 1, exp_done;
  logic [W-1:0] words[3] = '{8'hA5, 8'h3C, 8'hF0};

  initial begin
    forever begin
      @(posedge prog_clk);
      #1;
      if (prog_reset) begin
        check("reset_ctl", 32'({busy, done, ccff_shift_en, ccff_head, word_bus.word_ready,
                                rb_valid}), 32'h0);
        check("reset_bit_count", 32'(bit_count), 32'h0);
        check("reset_rb_data", 32'(rb_data), 32'h0);
        pos = 0; active = 0; last_final = 0; was_idle = 1;
        rb_exp.delete();
      end else begin
        if (start && was_idle) begin
          pos = 0; shift_cnt = 0; done_cnt = 0; captured = '0; active = 1;
          rb_got.delete();
        end
        exp_done = last_final;
        if (exp_done) active = 0;
        check("done", 32'(done), 32'(exp_done));
        if (done) done_cnt++;
        check("busy", 32'(busy), 32'(active));
        if (!active) check("ready_when_idle", 32'(word_bus.word_ready), 32'h0);
        check("bit_count", 32'(bit_count), pos);
        if (ccff_shift_en) begin
          if (!active || pos >= exp_stream.size()) fail_now("shift_overrun", "unexpected shift");
          else check("head", 32'(ccff_head), 32'(exp_stream[pos]));
          captured = {captured[L-2:0], ccff_head};
          pos++;
          shift_cnt++;
          last_final = (pos == L);
        end else begin
          check("head_idle", 32'(ccff_head), 32'h0);
          last_final = 0;
        end
`ifdef CCFF_READBACK_EN
        if (rb_valid) begin
          rb_got.push_back(rb_data);
          if (rb_exp.size() == 0) fail_now("rb_extra", "unexpected rb_valid");
          else check("rb_data", 32'(rb_data), 32'(rb_exp.pop_front()));
        end
`else
        check("rb_off", 32'({rb_valid, rb_data}), 32'h0);
`endif
        was_idle = !active && !exp_done;
      end
    end
  end

  task automatic prepare();
    logic [L-1:0] pre;
    logic [W-1:0] acc;
    int           n;
    exp_stream.delete();
    rb_exp.delete();
    for (int k = 0; k < 3; k++)
      for (int b = W - 1; b >= 0; b--)
        if (exp_stream.size() < L) exp_stream.push_back(words[k][b]);
    pre = ChainPreload;
    acc = '0;
    n   = 0;
    for (int k = 0; k < L; k++) begin
      acc = {acc[W-2:0], pre[L-1-k]};
      n++;
      if (n == W || k == L - 1) begin
        rb_exp.push_back(acc);
        acc = '0;
        n   = 0;
      end
    end
  endtask

  task automatic run_load(input int stall_cycles, input int reset_at, input int start_at);
    int           idx, stall_left, cycles;
    bit           fire, stalling;
    logic [W-1:0] rb_lit[3];
    rb_lit = '{8'hAB, 8'hCD, 8'h0E};
    prepare();
    @(negedge prog_clk);
    chain_load = 1;
    word_bus.word_valid = 1;
    word_bus.word_data  = words[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      chain_load = 0;
      check("ready_in_idle", 32'(word_bus.word_ready), 32'h0);
    end
    start = 1;
    fire = 0; idx = 0; stall_left = stall_cycles; cycles = 0;
    forever begin
      @(negedge prog_clk);
      cycles++;
      start = 0;
      if (fire) begin
        idx++;
        check("first_bit_latency", 32'(ccff_shift_en), 32'h1);
      end
      if (done_cnt != 0 && !busy) break;
      if (cycles > 200) begin
        fail_now("load_timeout", "done never seen");
        break;
      end
      if (reset_at >= 0 && pos == reset_at && ccff_shift_en) begin
        prog_reset = 1;
        word_bus.word_valid = 0;
        @(negedge prog_clk);
        prog_reset = 0;
        check("post_reset_bit_count", 32'(bit_count), 32'h0);
        check("post_reset_shift_en", 32'(ccff_shift_en), 32'h0);
        check("post_reset_busy", 32'(busy), 32'h0);
        return;
      end
      if (start_at >= 0 && pos == start_at && ccff_shift_en) start = 1;
      stalling = (idx == 1) && (stall_left > 0);
      if (stalling && word_bus.word_ready) begin
        check("stall_shift_en", 32'(ccff_shift_en), 32'h0);
        check("stall_head", 32'(ccff_head), 32'h0);
        check("stall_bit_count", 32'(bit_count), W);
        stall_left--;
      end
      word_bus.word_valid = (idx < 3) && !stalling;
      word_bus.word_data  = (idx < 3) ? words[idx] : '0;
      fire = word_bus.word_valid && word_bus.word_ready;
    end
    repeat (2) @(negedge prog_clk);
    check("shift_count", shift_cnt, L);
    check("stream", 32'(captured), 32'hA53CF);
    check("done_pulses", done_cnt, 1);
    check("bit_count_hold", 32'(bit_count), L);
`ifdef CCFF_READBACK_EN
    check("rb_count", rb_got.size(), 3);
    if (rb_got.size() == 3)
      for (int k = 0; k < 3; k++) check("rb_word", 32'(rb_got[k]), 32'(rb_lit[k]));
`else
    check("rb_count", rb_got.size(), 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_reset = 1;
    start = 0;
    chain_load = 1;
    word_bus.word_valid = 0;
    word_bus.word_data  = '0;
    repeat (3) @(negedge prog_clk);
    prog_reset = 0;
    chain_load = 0;
    repeat (2) @(negedge prog_clk);

    run_load(0, -1, -1);   // basic load, valid held high from IDLE
    prog_reset = 1;        // reset mid-IDLE while bit_count holds L
    repeat (2) @(negedge prog_clk);
    prog_reset = 0;
    @(negedge prog_clk);
    check("idle_reset_bit_count", 32'(bit_count), 32'h0);
    run_load(5, -1, -1);   // stall after the first word
    run_load(0, 5, -1);    // reset after five bits of 0xA5
    run_load(0, -1, -1);   // fresh load after the abort
    run_load(0, -1, 10);   // start pulsed mid-shift

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- On-chip bitstream writer for the FPGA configuration chain; it is the transmitter end of the ccff_head/ccff_tail serial protocol.
- Accepts WORD_WIDTH-bit bitstream words over a valid/ready handshake from the SoC-side management logic.
- Serializes each word MSB-first onto ccff_head and asserts a shift enable that gates prog_clk into the fabric.
- Counts shifted bits and stops after exactly CHAIN_LEN bits.

Parameters:
- WORD_WIDTH, 32, bits per input word.
- CHAIN_LEN, 2048, configuration-chain length in bits; must be >= 1.
- CNT_WIDTH, $clog2(CHAIN_LEN+1), width of bit_count.

Ports:
- prog_clk  input  1  programming clock; all logic is on its rising edge.
- prog_reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- word_data  input  WORD_WIDTH  bitstream word; MSB is shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader can accept a word this cycle.
- ccff_head  output  1  serial data into the configuration chain.
- ccff_shift_en  output  1  fabric prog_clk enable; one chain shift per asserted cycle.
- ccff_tail  input  1  chain tail; used only with CCFF_READBACK_EN.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle pulse when the load completes.
- bit_count  output  CNT_WIDTH  bits shifted since the last start.
- rb_data  output  WORD_WIDTH  readback word.
- rb_valid  output  1  one-cycle readback strobe.

Behaviour:
- Reset: prog_reset=1 at a rising edge forces the following, regardless of state or progress:
  - state=IDLE;
  - word_ready, ccff_head, ccff_shift_en, busy, done, rb_valid = 0;
  - bit_count, rb_data, internal shift register, internal counters = 0;
  - any partially shifted word is discarded.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - word_ready=0; word_valid is ignored.
  - start=1 -> LOAD and bit_count<=0.
- LOAD:
  - word_ready=1, ccff_shift_en=0, ccff_head=0.
  - On word_valid&word_ready: capture word_data into shreg; bits_left <= min(WORD_WIDTH, CHAIN_LEN-bit_count); go to SHIFT.
  - Without word_valid: remain in LOAD; this is a stall and no shift occurs.
- SHIFT:
  - word_ready=0, ccff_shift_en=1, ccff_head=shreg[WORD_WIDTH-1] (combinational from the register).
  - Each cycle: shreg shifts left with 0 fill, bit_count+1, bits_left-1.
  - Exit when the bit shifted this cycle makes bit_count==CHAIN_LEN: go to DONE.
  - Otherwise, when bits_left reaches 0: go to LOAD.
  - Last partial word: only its upper (CHAIN_LEN mod WORD_WIDTH) bits are shifted; the remaining bits are discarded.
- DONE: done=1 for exactly this cycle, then IDLE. bit_count holds CHAIN_LEN until the next start.
- Latency and throughput:
  - Word accepted at edge N; its MSB is on ccff_head during cycle N+1.
  - Sustained rate is WORD_WIDTH shift cycles plus 1 LOAD cycle per word.
- start while busy, or while in DONE, is ignored.
- word_valid held high through LOAD is consumed once per LOAD visit.
- bit_count never exceeds CHAIN_LEN.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined:
  - ccff_tail is sampled on every cycle with ccff_shift_en=1 and shifted into rb_shreg, LSB-in.
  - When WORD_WIDTH bits have been collected, or on the final chain bit: rb_data <= collected bits, right-aligned, zero-extended; rb_valid=1 for one cycle.
  - There is no back-pressure; a readback word that is not consumed is overwritten.
  - The readback counter is cleared on start.
- Not defined: rb_data=0 and rb_valid=0 permanently; ccff_tail is unused.

Test Plan:
- Reset: assert prog_reset 2 cycles mid-IDLE -> all outputs 0; bit_count=0.
- Basic load, WORD_WIDTH=8, CHAIN_LEN=20: start, then words 0xA5, 0x3C, 0xF0 presented with valid always high.
  - ccff_head over shift_en cycles = 10100101 00111100 1111.
  - Exactly 20 shift_en cycles; the low nibble of 0xF0 is never shifted.
  - done pulses once, the cycle after the 20th shift; bit_count=20.
- Stall: drop word_valid for 5 cycles after the first word.
  - ccff_shift_en=0, ccff_head=0, bit_count=8 held, word_ready=1 throughout the stall.
  - The remainder of the load completes identically to the basic load.
- Reset mid-shift: assert prog_reset after 5 bits of 0xA5.
  - Next cycle: IDLE, bit_count=0, shift_en=0.
  - A fresh start reloads from bit 0 and produces the full 20-bit sequence.
- Protocol guards:
  - start pulsed during SHIFT -> no effect on sequence or count.
  - word_valid=1 while in IDLE -> word_ready stays 0 and the word is not consumed.
- Readback (macro defined): ccff_tail driven by a 20-bit chain model preloaded 0xABCDE.
  - rb_valid pulses 3 times with rb_data = 0xAB, 0xCD, 0x0E.
  - Without the macro: rb_valid stays 0 for the whole load.
